song_sequencer: RTL and testbench

Game controller that drives the arrow playfield's pattern input. It steps through a song pattern ROM at a fixed beat rate and emits one-cycle `pattern_valid`/`pattern_out` strobes to the arrow game. It also runs the overall game state machine (idle, lead-in, play, tail, done) and accumulates per-player scores from the playfield's perfect-hit pulses. It sits between the top level (start/pause buttons, score display) and the arrow game plus a synchronous pattern ROM.

---
 rtl/song_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_song_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// song_sequencer
//
// Drives the arrow playfield's pattern input from a synchronous song ROM
// at a fixed beat rate. It also runs the game state machine
// (IDLE -> LEAD -> PLAY -> TAIL -> DONE) and counts each player's perfect hits.
//
// Ports
//   CLOCK_50                    system clock
//   reset                       asynchronous, active-high
//   start                       single-cycle start request (IDLE/DONE only)
//   pause                       level; freezes beat timing while high
//   rom_addr      [ADDR_W-1:0]  registered pattern ROM address
//   rom_data      [8:0]         ROM word, valid 1 cycle after rom_addr changes;
//                               bit 8 = end marker, bits 7:0 = pattern
//   perfect_hit_a/b             hit pulses from the arrow game
//   pattern_valid               one-cycle strobe for pattern_out
//   pattern_out   [7:0]         [7:4] player B, [3:0] player A
//   beat_tick                   one-cycle pulse per processed beat
//   score_a/b     [SCORE_W-1:0] saturating hit counters
//   game_state    [2:0]         IDLE=0 LEAD=1 PLAY=2 TAIL=3 DONE=4
//   game_over                   high while in DONE
module song_sequencer #(
  parameter int BEAT_CYCLES = 12500000,
  parameter int LEAD_BEATS  = 4,
  parameter int TAIL_BEATS  = 8,
  parameter int ADDR_W      = 6,
  parameter int SCORE_W     = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [8:0]         rom_data,
  input  logic               perfect_hit_a,
  input  logic               perfect_hit_b,
  output logic               pattern_valid,
  output logic [7:0]         pattern_out,
  output logic               beat_tick,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic [2:0]         game_state,
  output logic               game_over
);

  localparam int BC_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int MAXB = (LEAD_BEATS > TAIL_BEATS) ? LEAD_BEATS : TAIL_BEATS;
  localparam int BI_W = $clog2(MAXB + 1);

  localparam logic [BC_W-1:0]    BC_LAST   = BC_W'(BEAT_CYCLES - 1);
  localparam logic [BI_W-1:0]    LEAD_LAST = BI_W'(LEAD_BEATS - 1);
  localparam logic [BI_W-1:0]    TAIL_LAST = BI_W'(TAIL_BEATS - 1);
  localparam logic [ADDR_W-1:0]  ADDR_LAST = '1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEAD = 3'd1,
    S_PLAY = 3'd2,
    S_TAIL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [BC_W-1:0]    bc_q, bc_d;
  logic [BI_W-1:0]    bi_q, bi_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               pv_q, pv_d;
  logic [7:0]         pout_q, pout_d;
  logic               bt_q, bt_d;
  logic [SCORE_W-1:0] sa_q, sa_d;
  logic [SCORE_W-1:0] sb_q, sb_d;
  logic               go_q, go_d;
  logic               running;
  logic               tick;

  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    bi_d    = bi_q;
    addr_d  = addr_q;
    pv_d    = 1'b0;
    pout_d  = pout_q;
    sa_d    = sa_q;
    sb_d    = sb_q;

    running = (state_q == S_LEAD) || (state_q == S_PLAY) || (state_q == S_TAIL);
    tick    = running && !pause && (bc_q == BC_LAST);
    bt_d    = tick;

    if (running && !pause) begin
      bc_d = tick ? '0 : bc_q + 1'b1;
    end

    // Scores keep counting while paused; only the game phase gates them.
    if ((state_q == S_PLAY) || (state_q == S_TAIL)) begin
      if (perfect_hit_a && (sa_q != SCORE_MAX)) sa_d = sa_q + 1'b1;
      if (perfect_hit_b && (sb_q != SCORE_MAX)) sb_d = sb_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LEAD;
          bc_d    = '0;
          bi_d    = '0;
          addr_d  = '0;
          sa_d    = '0;
          sb_d    = '0;
        end
      end
      S_LEAD: begin
        if (tick) begin
          bi_d = bi_q + 1'b1;
          if (bi_q == LEAD_LAST) state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        // rom_data was addressed on the previous tick, so it has had a full
        // beat to settle by the time it is consumed here.
        if (tick) begin
          if (rom_data[8]) begin
            state_d = S_TAIL;
            bi_d    = '0;
          end else begin
            pv_d   = 1'b1;
            pout_d = rom_data[7:0];
            if (addr_q == ADDR_LAST) begin
              // Last ROM entry: no wrap, hold the address and drain.
              state_d = S_TAIL;
              bi_d    = '0;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end
        end
      end
      S_TAIL: begin
        if (tick) begin
          bi_d = bi_q + 1'b1;
          if (bi_q == TAIL_LAST) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    go_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      bc_q    <= '0;
      bi_q    <= '0;
      addr_q  <= '0;
      pv_q    <= 1'b0;
      pout_q  <= '0;
      bt_q    <= 1'b0;
      sa_q    <= '0;
      sb_q    <= '0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      bi_q    <= bi_d;
      addr_q  <= addr_d;
      pv_q    <= pv_d;
      pout_q  <= pout_d;
      bt_q    <= bt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      go_q    <= go_d;
    end
  end

  assign rom_addr      = addr_q;
  assign pattern_valid = pv_q;
  assign pattern_out   = pout_q;
  assign beat_tick     = bt_q;
  assign score_a       = sa_q;
  assign score_b       = sb_q;
  assign game_state    = state_q;
  assign game_over     = go_q;

endmodule

// File: tb/tb_song_sequencer.sv
module tb_song_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // DUT 1: basic song, pause, scoring, reset/restart
  logic       rst1, start1, pause1, hita1, hitb1;
  logic [5:0] rom_addr1;
  logic [8:0] rom_data1;
  logic       pv1, bt1, go1;
  logic [7:0] pout1, sa1, sb1;
  logic [2:0] gs1;

  // DUT 2: 4-entry ROM with no end marker, 2-bit scores
  logic       rst2, start2, pause2, hita2, hitb2;
  logic [1:0] rom_addr2;
  logic [8:0] rom_data2;
  logic       pv2, bt2, go2;
  logic [7:0] pout2;
  logic [1:0] sa2, sb2;
  logic [2:0] gs2;

  logic [8:0] mem1 [0:63];
  logic [8:0] mem2 [0:3];

  always @(posedge clk) rom_data1 <= mem1[rom_addr1];
  always @(posedge clk) rom_data2 <= mem2[rom_addr2];

  song_sequencer #(.BEAT_CYCLES(4), .LEAD_BEATS(2), .TAIL_BEATS(2), .ADDR_W(6), .SCORE_W(8)) dut1 (
    .CLOCK_50(clk), .reset(rst1), .start(start1), .pause(pause1),
    .rom_addr(rom_addr1), .rom_data(rom_data1),
    .perfect_hit_a(hita1), .perfect_hit_b(hitb1),
    .pattern_valid(pv1), .pattern_out(pout1), .beat_tick(bt1),
    .score_a(sa1), .score_b(sb1), .game_state(gs1), .game_over(go1)
  );

  song_sequencer #(.BEAT_CYCLES(4), .LEAD_BEATS(2), .TAIL_BEATS(2), .ADDR_W(2), .SCORE_W(2)) dut2 (
    .CLOCK_50(clk), .reset(rst2), .start(start2), .pause(pause2),
    .rom_addr(rom_addr2), .rom_data(rom_data2),
    .perfect_hit_a(hita2), .perfect_hit_b(hitb2),
    .pattern_valid(pv2), .pattern_out(pout2), .beat_tick(bt2),
    .score_a(sa2), .score_b(sb2), .game_state(gs2), .game_over(go2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves time just after edge E0 (k = 0).
  task automatic start_game1();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
  endtask

  task automatic start_game2();
    start2 = 1'b1;
    step();
    start2 = 1'b0;
  endtask

  task automatic test_reset();
    rst1 = 1'b1;
    rst2 = 1'b1;
    step();
    step();
    checks++; if (gs1 !== 3'd0)    begin errors++; $display("FAIL reset_state got %0d exp 0", gs1); end
    checks++; if (rom_addr1 !== 6'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", rom_addr1); end
    checks++; if (pv1 !== 1'b0 || bt1 !== 1'b0 || go1 !== 1'b0)
      begin errors++; $display("FAIL reset_strobes got pv=%b bt=%b go=%b exp 0 0 0", pv1, bt1, go1); end
    checks++; if (pout1 !== 8'd0 || sa1 !== 8'd0 || sb1 !== 8'd0)
      begin errors++; $display("FAIL reset_data got pout=%h sa=%0d sb=%0d exp 0 0 0", pout1, sa1, sb1); end
    checks++; if (gs2 !== 3'd0 || sa2 !== 2'd0 || rom_addr2 !== 2'd0)
      begin errors++; $display("FAIL reset_dut2 got gs=%0d sa=%0d addr=%0d exp 0 0 0", gs2, sa2, rom_addr2); end
    rst1 = 1'b0;
    rst2 = 1'b0;
    step();
    $display("reset: done");
  endtask

  task automatic test_basic();
    logic [2:0] es;
    logic [5:0] ea;
    start_game1();
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) step();
      es = (k < 8) ? 3'd1 : (k < 20) ? 3'd2 : (k < 28) ? 3'd3 : 3'd4;
      ea = (k < 12) ? 6'd0 : (k < 16) ? 6'd1 : 6'd2;
      checks++; if (gs1 !== es) begin errors++; $display("FAIL basic_state k=%0d got %0d exp %0d", k, gs1, es); end
      checks++; if (pv1 !== (k == 12 || k == 16)) begin errors++; $display("FAIL basic_valid k=%0d got %b exp %b", k, pv1, (k == 12 || k == 16)); end
      checks++; if (rom_addr1 !== ea) begin errors++; $display("FAIL basic_addr k=%0d got %0d exp %0d", k, rom_addr1, ea); end
      checks++; if (go1 !== (k >= 28)) begin errors++; $display("FAIL basic_over k=%0d got %b exp %b", k, go1, (k >= 28)); end
      if (k > 0) begin
        checks++; if (bt1 !== (k % 4 == 0 && k <= 28)) begin errors++; $display("FAIL basic_tick k=%0d got %b exp %b", k, bt1, (k % 4 == 0 && k <= 28)); end
      end
      if (k == 12) begin
        checks++; if (pout1 !== 8'h11) begin errors++; $display("FAIL basic_pat0 got %h exp 11", pout1); end
      end
      if (k == 16) begin
        checks++; if (pout1 !== 8'h82) begin errors++; $display("FAIL basic_pat1 got %h exp 82", pout1); end
      end
      if (pv1) $display("basic: strobe k=%0d pattern=%h", k, pout1);
    end
  endtask

  task automatic test_pause();
    logic [2:0] es;
    logic [5:0] ea;
    start_game1();
    for (int k = 0; k <= 33; k++) begin
      if (k > 0) step();
      // Edges k=14..18 sample pause high: five stalled cycles.
      pause1 = (k >= 13 && k < 18);
      es = (k < 8) ? 3'd1 : (k < 25) ? 3'd2 : (k < 33) ? 3'd3 : 3'd4;
      ea = (k < 12) ? 6'd0 : (k < 21) ? 6'd1 : 6'd2;
      checks++; if (gs1 !== es) begin errors++; $display("FAIL pause_state k=%0d got %0d exp %0d", k, gs1, es); end
      checks++; if (pv1 !== (k == 12 || k == 21)) begin errors++; $display("FAIL pause_valid k=%0d got %b exp %b", k, pv1, (k == 12 || k == 21)); end
      checks++; if (rom_addr1 !== ea) begin errors++; $display("FAIL pause_addr k=%0d got %0d exp %0d", k, rom_addr1, ea); end
      if (k == 21) begin
        checks++; if (pout1 !== 8'h82) begin errors++; $display("FAIL pause_pat got %h exp 82", pout1); end
      end
      if (pv1) $display("pause: strobe k=%0d pattern=%h", k, pout1);
    end
    pause1 = 1'b0;
  endtask

  task automatic test_scoring();
    logic       pa [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       pb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] ea [4] = '{8'd1, 8'd2, 8'd3, 8'd3};
    logic [7:0] eb [4] = '{8'd0, 8'd1, 8'd1, 8'd2};
    int k;
    start_game1();
    k = 0;
    repeat (3) begin step(); k++; end
    hita1 = 1'b1; hitb1 = 1'b1;           // hits during LEAD
    step(); k++;
    hita1 = 1'b0; hitb1 = 1'b0;
    checks++; if (sa1 !== 8'd0 || sb1 !== 8'd0) begin errors++; $display("FAIL score_lead got a=%0d b=%0d exp 0 0", sa1, sb1); end
    while (k < 9) begin step(); k++; end
    for (int i = 0; i < 4; i++) begin
      hita1 = pa[i]; hitb1 = pb[i];
      step(); k++;
      hita1 = 1'b0; hitb1 = 1'b0;
      checks++; if (sa1 !== ea[i] || sb1 !== eb[i])
        begin errors++; $display("FAIL score_play i=%0d got a=%0d b=%0d exp %0d %0d", i, sa1, sb1, ea[i], eb[i]); end
      $display("scoring: hit a=%b b=%b -> a=%0d b=%0d", pa[i], pb[i], sa1, sb1);
    end
    while (k < 28) begin step(); k++; end
    checks++; if (gs1 !== 3'd4) begin errors++; $display("FAIL score_done_state got %0d exp 4", gs1); end
    hita1 = 1'b1; hitb1 = 1'b1;           // hits during DONE
    step();
    step();
    hita1 = 1'b0; hitb1 = 1'b0;
    checks++; if (sa1 !== 8'd3 || sb1 !== 8'd2) begin errors++; $display("FAIL score_done got a=%0d b=%0d exp 3 2", sa1, sb1); end
  endtask

  task automatic test_restart();
    int k;
    start_game1();                        // from DONE with scores 3/2
    k = 0;
    checks++; if (gs1 !== 3'd1) begin errors++; $display("FAIL restart_state got %0d exp 1", gs1); end
    checks++; if (sa1 !== 8'd0 || sb1 !== 8'd0 || go1 !== 1'b0)
      begin errors++; $display("FAIL restart_clear got a=%0d b=%0d go=%b exp 0 0 0", sa1, sb1, go1); end
    while (k < 9) begin step(); k++; end
    start1 = 1'b1;                        // ignored in PLAY
    step(); k++;
    start1 = 1'b0;
    checks++; if (gs1 !== 3'd2) begin errors++; $display("FAIL start_ignored got %0d exp 2", gs1); end
    while (k < 12) begin step(); k++; end
    checks++; if (pv1 !== 1'b1 || pout1 !== 8'h11)
      begin errors++; $display("FAIL start_ignored_strobe got pv=%b pat=%h exp 1 11", pv1, pout1); end
    $display("restart: strobe k=%0d pattern=%h", k, pout1);
  endtask

  task automatic test_reset_mid_play();
    hita1 = 1'b1;
    step();                               // k=13, still PLAY
    hita1 = 1'b0;
    checks++; if (sa1 !== 8'd1 || rom_addr1 !== 6'd1)
      begin errors++; $display("FAIL midplay_pre got a=%0d addr=%0d exp 1 1", sa1, rom_addr1); end
    rst1 = 1'b1;
    step();
    checks++; if (gs1 !== 3'd0 || rom_addr1 !== 6'd0 || sa1 !== 8'd0 || sb1 !== 8'd0)
      begin errors++; $display("FAIL midplay_reset got gs=%0d addr=%0d a=%0d b=%0d exp 0 0 0 0", gs1, rom_addr1, sa1, sb1); end
    checks++; if (pv1 !== 1'b0 || bt1 !== 1'b0 || go1 !== 1'b0 || pout1 !== 8'd0)
      begin errors++; $display("FAIL midplay_outs got pv=%b bt=%b go=%b pat=%h exp 0 0 0 00", pv1, bt1, go1, pout1); end
    rst1 = 1'b0;
    repeat (6) step();
    checks++; if (gs1 !== 3'd0) begin errors++; $display("FAIL midplay_idle got %0d exp 0", gs1); end
    $display("reset mid-play: state=%0d", gs1);
  endtask

  task automatic test_saturation();
    logic [1:0] es [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    int k;
    start_game2();
    k = 0;
    while (k < 9) begin step(); k++; end
    for (int i = 0; i < 5; i++) begin
      hita2 = 1'b1;
      step(); k++;
      checks++; if (sa2 !== es[i]) begin errors++; $display("FAIL saturate i=%0d got %0d exp %0d", i, sa2, es[i]); end
      $display("saturation: hit %0d -> a=%0d", i, sa2);
    end
    hita2 = 1'b0;
    while (k < 32) begin step(); k++; end
    checks++; if (gs2 !== 3'd4 || sa2 !== 2'd3)
      begin errors++; $display("FAIL saturate_done got gs=%0d a=%0d exp 4 3", gs2, sa2); end
  endtask

  task automatic test_full_rom();
    logic [7:0] ep [4] = '{8'h01, 8'h20, 8'h00, 8'hFF};
    logic [2:0] es;
    logic [1:0] ea;
    start_game2();
    checks++; if (sa2 !== 2'd0) begin errors++; $display("FAIL fullrom_clear got %0d exp 0", sa2); end
    for (int k = 0; k <= 32; k++) begin
      if (k > 0) step();
      es = (k < 8) ? 3'd1 : (k < 24) ? 3'd2 : (k < 32) ? 3'd3 : 3'd4;
      ea = (k < 12) ? 2'd0 : (k < 16) ? 2'd1 : (k < 20) ? 2'd2 : 2'd3;
      checks++; if (gs2 !== es) begin errors++; $display("FAIL fullrom_state k=%0d got %0d exp %0d", k, gs2, es); end
      checks++; if (rom_addr2 !== ea) begin errors++; $display("FAIL fullrom_addr k=%0d got %0d exp %0d", k, rom_addr2, ea); end
      checks++; if (pv2 !== (k >= 12 && k <= 24 && k % 4 == 0))
        begin errors++; $display("FAIL fullrom_valid k=%0d got %b", k, pv2); end
      if (k >= 12 && k <= 24 && k % 4 == 0) begin
        checks++; if (pout2 !== ep[(k - 12) / 4])
          begin errors++; $display("FAIL fullrom_pat k=%0d got %h exp %h", k, pout2, ep[(k - 12) / 4]); end
      end
      if (pv2) $display("full rom: strobe k=%0d pattern=%h", k, pout2);
    end
  endtask

  initial begin
    rst1 = 1'b0; start1 = 1'b0; pause1 = 1'b0; hita1 = 1'b0; hitb1 = 1'b0;
    rst2 = 1'b0; start2 = 1'b0; pause2 = 1'b0; hita2 = 1'b0; hitb2 = 1'b0;
    for (int i = 0; i < 64; i++) mem1[i] = 9'h100;
    mem1[0] = 9'h011;
    mem1[1] = 9'h082;
    mem2[0] = 9'h001;
    mem2[1] = 9'h020;
    mem2[2] = 9'h000;
    mem2[3] = 9'h0FF;

    test_reset();
    test_basic();
    test_pause();
    test_scoring();
    test_restart();
    test_reset_mid_play();
    test_saturation();
    test_full_rom();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "timeout");
  end

endmodule
